// File: rtl/serial_add_sub_if.sv
// Start/busy/done handshake bundle for the bit-serial adder/subtractor.
// SERIAL_AS_OVF_EN adds the signed-overflow flag to the bundle.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_AS_OVF_EN
    logic             ovf;

    modport master (output start, mode, a, b, input busy, done, result, cout, ovf);
    modport slave  (input start, mode, a, b, output busy, done, result, cout, ovf);
`else
    modport master (output start, mode, a, b, input busy, done, result, cout);
    modport slave  (input start, mode, a, b, output busy, done, result, cout);
`endif
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder/subtractor slice, LSB first, one bit per clock.
// Optional signed overflow output enabled by SERIAL_AS_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; result/cout hold the last answer
// RUN   | one operand bit processed per edge, result shifts in from the MSB side
// DONE  | one-cycle done pulse; start here begins the next op back-to-back
module serial_add_sub #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_sub_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_AS_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic bit_a;
    logic bit_b;
    logic sum_bit;
    logic carry_nxt;

    // Operands shift right so the current bit is always at position 0.
    always_comb begin
        bit_a     = a_q[0];
        bit_b     = b_q[0];
        sum_bit   = bit_a ^ bit_b ^ carry_q;
        if (mode_q)
            carry_nxt = (~bit_a & bit_b) | (~bit_a & carry_q) | (bit_b & carry_q);
        else
            carry_nxt = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef SERIAL_AS_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    state_d = ST_RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    mode_d  = bus.mode;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                result_d = {sum_bit, result_q[WIDTH-1:1]};
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                carry_d  = carry_nxt;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    cout_d  = carry_nxt;
`ifdef SERIAL_AS_OVF_EN
                    // On the last edge bit_a/bit_b are the operand sign bits.
                    if (mode_q)
                        ovf_d = (bit_a != bit_b) && (sum_bit != bit_a);
                    else
                        ovf_d = (bit_a == bit_b) && (sum_bit != bit_a);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_AS_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef SERIAL_AS_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy   = (state_q == ST_RUN);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
`ifdef SERIAL_AS_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule
